// File: rtl/cv32e40s_pkg.sv
// Shared definitions for the dummy instruction generator.
//   dummy_gen_state_e : burst FSM states (COUNT, ISSUE, GAP)
//   OPCODE_/FUNCT3_/FUNCT7_ : fields used to build dummy instructions
//   dummy_encode()    : builds a dummy instruction from an LFSR snapshot
package cv32e40s_pkg;

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } dummy_gen_state_e;

    localparam logic [6:0] OPCODE_OP          = 7'h33;
    localparam logic [6:0] OPCODE_BRANCH      = 7'h63;

    localparam logic [2:0] FUNCT3_DUMMY_ADD   = 3'b000;
    localparam logic [2:0] FUNCT3_DUMMY_MUL   = 3'b000;
    localparam logic [2:0] FUNCT3_DUMMY_AND   = 3'b111;
    localparam logic [2:0] FUNCT3_DUMMY_BLTU  = 3'b110;

    localparam logic [6:0] FUNCT7_DUMMY_ADD   = 7'b0000000;
    localparam logic [6:0] FUNCT7_DUMMY_MUL   = 7'b0000001;
    localparam logic [6:0] FUNCT7_DUMMY_AND   = 7'b0000000;

    // lfsr[1:0] picks the operation, lfsr[12:8]/lfsr[20:16] the sources.
    // OP forms write x0; the branch form has a zero offset so it is a no-op
    // whether taken or not.
    function automatic logic [31:0] dummy_encode(input logic [31:0] lfsr,
                                                 input logic        mul_en);
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] instr;
        rs1 = lfsr[12:8];
        rs2 = lfsr[20:16];
        case (lfsr[1:0])
            2'b00:   instr = {FUNCT7_DUMMY_ADD, rs2, rs1, FUNCT3_DUMMY_ADD, 5'd0, OPCODE_OP};
            2'b01:   instr = mul_en ? {FUNCT7_DUMMY_MUL, rs2, rs1, FUNCT3_DUMMY_MUL, 5'd0, OPCODE_OP}
                                    : {FUNCT7_DUMMY_ADD, rs2, rs1, FUNCT3_DUMMY_ADD, 5'd0, OPCODE_OP};
            2'b10:   instr = {FUNCT7_DUMMY_AND, rs2, rs1, FUNCT3_DUMMY_AND, 5'd0, OPCODE_OP};
            default: instr = {7'd0, rs2, rs1, FUNCT3_DUMMY_BLTU, 5'd0, OPCODE_BRANCH};
        endcase
        return instr;
    endfunction

endpackage

// File: rtl/cv32e40s_dummy_interval_cnt.sv
// Issued-instruction counter with randomised threshold.
//   clk, rst_n          : clock, synchronous active-low reset
//   rnddummy_i          : counter and threshold only update while set
//   en_i                : insertion enabled (allow && rnddummy)
//   cntrst_i            : counter reset request
//   start_i             : burst starting this cycle (counter reset)
//   instr_issued_i      : count one issued instruction
//   lfsr_thr_i          : LFSR bits used for the threshold
//   rnddummyfreq_i      : frequency mask for the threshold
//   interval_hit_o      : count has passed the threshold
module cv32e40s_dummy_interval_cnt
    import cv32e40s_pkg::*;
#(
    parameter  int MAX_DUMMY_INTERVAL = 64,
    localparam int IW    = $clog2(MAX_DUMMY_INTERVAL),
    localparam int CNT_W = $clog2(MAX_DUMMY_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rnddummy_i,
    input  logic          en_i,
    input  logic          cntrst_i,
    input  logic          start_i,
    input  logic          instr_issued_i,
    input  logic [IW-1:0] lfsr_thr_i,
    input  logic [IW-3:0] rnddummyfreq_i,
    output logic          interval_hit_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]    thr_q, thr_d;
    logic             cnt_clr;

    assign cnt_clr = !en_i || cntrst_i || start_i;

    always_comb begin
        cnt_d = cnt_q;
        thr_d = thr_q;
        if (rnddummy_i) begin
            if (cnt_clr) begin
                cnt_d = '0;
                // Low two bits always kept so the interval is never forced to 0.
                thr_d = lfsr_thr_i & {rnddummyfreq_i, 2'b11};
            end else if (instr_issued_i && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            thr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            thr_q <= thr_d;
        end
    end

    assign interval_hit_o = cnt_q > CNT_W'(thr_q);

endmodule

// File: rtl/cv32e40s_dummy_instr_gen.sv
// Dummy instruction burst generator.
// Counts issued instructions; once an LFSR-randomised interval is passed it
// delivers a burst of 1..MAX_BURST dummy instructions over valid/ready.
//   clk, rst_n      : clock, synchronous active-low reset
//   instr_issued_i  : real instruction issued
//   allow_dummy_i   : controller permits insertion
//   rnddummy_i      : feature enable
//   rnddummyfreq_i  : threshold frequency mask
//   burst_len_i     : requested beats per burst (0 -> 1, clamped to MAX_BURST)
//   cntrst_i        : counter reset request
//   lfsr_i          : LFSR value (threshold + encoding source)
//   dummy_valid_o / dummy_ready_i / dummy_instr_o / dummy_last_o : beat channel
//   lfsr_shift_o    : LFSR advance, one per accepted beat
//   busy_o          : burst in progress
module cv32e40s_dummy_instr_gen
    import cv32e40s_pkg::*;
#(
    parameter  int MAX_DUMMY_INTERVAL = 64,
    parameter  int MAX_BURST          = 4,
    parameter  int MUL_EN             = 1,
    localparam int IW                 = $clog2(MAX_DUMMY_INTERVAL),
    localparam int BW                 = $clog2(MAX_BURST) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_issued_i,
    input  logic          allow_dummy_i,
    input  logic          rnddummy_i,
    input  logic [IW-3:0] rnddummyfreq_i,
    input  logic [BW-1:0] burst_len_i,
    input  logic          cntrst_i,
    input  logic [31:0]   lfsr_i,
    output logic          dummy_valid_o,
    input  logic          dummy_ready_i,
    output logic [31:0]   dummy_instr_o,
    output logic          dummy_last_o,
    output logic          lfsr_shift_o,
    output logic          busy_o
);

    dummy_gen_state_e state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [BW-1:0]    len_q, len_d;
    logic [BW-1:0]    eff_len;
    logic             en;
    logic             interval_hit;
    logic             start;
    logic             valid;
    logic             last;
    logic             shift;

    assign en = allow_dummy_i && rnddummy_i;

    cv32e40s_dummy_interval_cnt #(
        .MAX_DUMMY_INTERVAL (MAX_DUMMY_INTERVAL)
    ) u_interval_cnt (
        .clk            (clk),
        .rst_n          (rst_n),
        .rnddummy_i     (rnddummy_i),
        .en_i           (en),
        .cntrst_i       (cntrst_i),
        .start_i        (start),
        .instr_issued_i (instr_issued_i),
        .lfsr_thr_i     (lfsr_i[IW+23:24]),
        .rnddummyfreq_i (rnddummyfreq_i),
        .interval_hit_o (interval_hit)
    );

    always_comb begin
        if (burst_len_i == '0) begin
            eff_len = BW'(1);
        end else if (burst_len_i > BW'(MAX_BURST)) begin
            eff_len = BW'(MAX_BURST);
        end else begin
            eff_len = burst_len_i;
        end
    end

    assign last = (state_q == ISSUE) && (beat_q == len_q - 1'b1);

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        beat_d  = beat_q;
        len_d   = len_q;
        start   = 1'b0;
        valid   = 1'b0;
        shift   = 1'b0;
        case (state_q)
            COUNT: begin
                if (en && interval_hit) begin
                    state_d = ISSUE;
                    start   = 1'b1;
                    instr_d = dummy_encode(lfsr_i, MUL_EN != 0);
                    beat_d  = '0;
                    len_d   = eff_len;
                end
            end
            ISSUE: begin
                // A presented beat is held until accepted, even if en drops.
                valid = 1'b1;
                if (dummy_ready_i) begin
                    shift  = 1'b1;
                    beat_d = beat_q + 1'b1;
                    state_d = (last || !en) ? COUNT : GAP;
                end
            end
            GAP: begin
                // One cycle for the LFSR to advance before the next snapshot.
                if (!en) begin
                    state_d = COUNT;
                end else begin
                    instr_d = dummy_encode(lfsr_i, MUL_EN != 0);
                    state_d = ISSUE;
                end
            end
            default: state_d = COUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COUNT;
            instr_q <= '0;
            beat_q  <= '0;
            len_q   <= BW'(1);
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
        end
    end

    assign dummy_valid_o = valid;
    assign dummy_instr_o = valid ? instr_q : 32'd0;
    assign dummy_last_o  = last;
    assign lfsr_shift_o  = shift;
    assign busy_o        = (state_q != COUNT);

endmodule

// File: tb/tb_cv32e40s_dummy_instr_gen.sv
module tb_cv32e40s_dummy_instr_gen;

    localparam int MDI = 64;
    localparam int MB  = 4;
    localparam int IW  = $clog2(MDI);
    localparam int BW  = $clog2(MB) + 1;
    localparam int CNT_MAX = (1 << $clog2(MDI + 1)) - 1;

    logic          clk;
    logic          rst_n;
    logic          issued, allow, rnd, cntrst, ready;
    logic [IW-3:0] freq;
    logic [BW-1:0] bl;
    logic [31:0]   lfsr;
    logic          valid, last, shift, busy;
    logic [31:0]   instr;
    logic          valid_nm, last_nm, shift_nm, busy_nm;
    logic [31:0]   instr_nm;

    int n_pass  = 0;
    int n_total = 0;

    cv32e40s_dummy_instr_gen #(.MAX_DUMMY_INTERVAL(MDI), .MAX_BURST(MB), .MUL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .instr_issued_i(issued), .allow_dummy_i(allow),
        .rnddummy_i(rnd), .rnddummyfreq_i(freq), .burst_len_i(bl), .cntrst_i(cntrst),
        .lfsr_i(lfsr), .dummy_valid_o(valid), .dummy_ready_i(ready), .dummy_instr_o(instr),
        .dummy_last_o(last), .lfsr_shift_o(shift), .busy_o(busy));

    cv32e40s_dummy_instr_gen #(.MAX_DUMMY_INTERVAL(MDI), .MAX_BURST(MB), .MUL_EN(0)) dut_nm (
        .clk(clk), .rst_n(rst_n), .instr_issued_i(issued), .allow_dummy_i(allow),
        .rnddummy_i(rnd), .rnddummyfreq_i(freq), .burst_len_i(bl), .cntrst_i(cntrst),
        .lfsr_i(lfsr), .dummy_valid_o(valid_nm), .dummy_ready_i(ready), .dummy_instr_o(instr_nm),
        .dummy_last_o(last_nm), .lfsr_shift_o(shift_nm), .busy_o(busy_nm));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Instruction built field by field from the RISC-V formats.
    function automatic logic [31:0] ref_enc(input logic [31:0] l, input bit mul);
        int f7, f3, op, rs1, rs2;
        rs1 = int'((l >> 8) & 31);
        rs2 = int'((l >> 16) & 31);
        case (l & 3)
            0:       begin f7 = 0;         f3 = 0; op = 51; end
            1:       begin f7 = mul ? 1:0; f3 = 0; op = 51; end
            2:       begin f7 = 0;         f3 = 7; op = 51; end
            default: begin f7 = 0;         f3 = 6; op = 99; end
        endcase
        return 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | op);
    endfunction

    // ---------------- behavioural model ----------------
    int          m_cnt, m_thr, m_sent, m_len;
    bit          m_busy, m_gap, m_en, m_hit;
    logic [31:0] m_src;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt = 0; m_thr = 0; m_busy = 0; m_gap = 0; m_sent = 0; m_len = 1; m_src = 0;
        end else begin
            m_en  = allow && rnd;
            m_hit = !m_busy && m_en && (m_cnt > m_thr);
            if (!m_busy) begin
                if (m_hit) begin
                    m_busy = 1; m_gap = 0; m_sent = 0; m_src = lfsr;
                    m_len = (bl == 0) ? 1 : ((int'(bl) > MB) ? MB : int'(bl));
                end
            end else if (!m_gap) begin
                if (ready) begin
                    m_sent++;
                    if (m_sent == m_len || !m_en) m_busy = 0;
                    else m_gap = 1;
                end
            end else begin
                if (!m_en) m_busy = 0;
                else begin m_gap = 0; m_src = lfsr; end
            end
            if (rnd) begin
                if (!m_en || cntrst || m_hit) begin
                    m_cnt = 0;
                    m_thr = int'((lfsr >> 24) & (MDI - 1)) & ((int'(freq) << 2) | 3);
                end else if (issued && m_cnt < CNT_MAX) begin
                    m_cnt++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit ev;
        ev = m_busy && !m_gap;
        chk("valid", valid, ev);
        chk("instr", instr, ev ? ref_enc(m_src, 1) : 32'd0);
        chk("instr_nomul", instr_nm, ev ? ref_enc(m_src, 0) : 32'd0);
        chk("last", last, ev && (m_sent == m_len - 1));
        chk("shift", shift, ev && ready);
        chk("busy", busy, m_busy);
        chk("busy_nomul", busy_nm, m_busy);
        chk("cnt", dut.u_interval_cnt.cnt_q, m_cnt);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ends in the first ISSUE cycle of a new burst (threshold 0 from l[31:24]=0).
    task automatic trigger(input logic [31:0] l);
        lfsr = l; cntrst = 1'b1;
        step();
        cntrst = 1'b0; issued = 1'b1;
        step();
        issued = 1'b0;
        step();
    endtask

    task automatic count_beats(input int cycles, output int n, output int nl);
        n = 0; nl = 0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            if (valid && ready) begin
                n++;
                if (last) nl = n;
            end
            step();
        end
    endtask

    logic [31:0] held;
    int nb, nl, nbusy;

    initial begin
        rst_n = 1'b0; issued = 0; allow = 1; rnd = 1; cntrst = 0; ready = 1;
        freq = '0; bl = BW'(1); lfsr = 32'h3F00_0000;
        step(); step();
        #1;
        chk("rst_valid", valid, 0); chk("rst_instr", instr, 0); chk("rst_busy", busy, 0);
        chk("rst_last", last, 0); chk("rst_shift", shift, 0);

        // Threshold 3: four issues, valid on the following cycle.
        rst_n = 1'b1; cntrst = 1'b1;
        step();
        cntrst = 1'b0; issued = 1'b1;
        repeat (4) step();
        issued = 1'b0;
        #1 chk("lat_pre_valid", valid, 0);
        step();
        #1;
        chk("lat_valid", valid, 1); chk("lat_last", last, 1);
        chk("lat_shift", shift, 1); chk("lat_instr", instr, 32'h0000_0033);
        step();
        #1 chk("lat_busy_drop", busy, 0);

        // Encodings
        trigger(32'h000A_0502);
        #1 chk("enc_and", instr, 32'h00A2_F033);
        step();
        trigger(32'h000A_0503);
        #1 chk("enc_bltu", instr, 32'h00A2_E063);
        step();
        trigger(32'h000A_0501);
        #1 chk("enc_mul", instr, 32'h02A2_8033); chk("enc_mul_off", instr_nm, 32'h00A2_8033);
        step();

        // Backpressure on beat 0 of a 3-beat burst
        bl = BW'(3); ready = 1'b0;
        trigger(32'h000A_0502);
        held = instr;
        lfsr = 32'h0011_2233;
        repeat (5) begin
            #1 chk("hold_instr", instr, held); chk("hold_shift", shift, 0);
            step();
        end
        ready = 1'b1;
        count_beats(8, nb, nl);
        chk("bp_beats", nb, 3); chk("bp_last_on", nl, 3); chk("bp_busy", busy, 0);

        // allow drops while beat 1 of 4 is valid
        bl = BW'(4); lfsr = 32'h000A_0502;
        trigger(32'h000A_0502);
        step(); step();
        allow = 1'b0; ready = 1'b0;
        #1 chk("abort_valid", valid, 1);
        step();
        #1 chk("abort_keep", valid, 1);
        ready = 1'b1;
        #1 chk("abort_hs", shift, 1);
        step();
        #1 chk("abort_busy", busy, 0); chk("abort_cnt", dut.u_interval_cnt.cnt_q, 0);
        nb = 0;
        repeat (4) begin #1 if (valid) nb++; step(); end
        chk("abort_nobeat", nb, 0);
        allow = 1'b1;

        // Burst length clamping
        bl = BW'(0);
        trigger(32'h000A_0500);
        count_beats(6, nb, nl);
        chk("len0_beats", nb, 1);
        bl = BW'(7);
        trigger(32'h000A_0500);
        count_beats(12, nb, nl);
        chk("len7_beats", nb, 4); chk("len7_last", nl, 4);

        // Reset mid-burst
        bl = BW'(4); ready = 1'b0;
        trigger(32'h000A_0502);
        #1 chk("mid_valid", valid, 1);
        rst_n = 1'b0; ready = 1'b1;
        step();
        #1;
        chk("mid_rst_valid", valid, 0); chk("mid_rst_instr", instr, 0);
        chk("mid_rst_busy", busy, 0); chk("mid_rst_last", last, 0); chk("mid_rst_shift", shift, 0);
        rst_n = 1'b1;

        // cntrst every cycle keeps the counter from ever passing the threshold
        lfsr = 32'h3F00_0000; cntrst = 1'b1; issued = 1'b1; nbusy = 0;
        repeat (30) begin #1 if (busy) nbusy++; step(); end
        chk("cntrst_noins", nbusy, 0);
        cntrst = 1'b0; issued = 1'b0;

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            rst_n  = ($urandom_range(0, 299) != 0);
            issued = ($urandom_range(0, 9) < 6);
            allow  = ($urandom_range(0, 19) != 0);
            rnd    = ($urandom_range(0, 29) != 0);
            cntrst = ($urandom_range(0, 39) == 0);
            ready  = ($urandom_range(0, 9) < 7);
            freq   = IW'($urandom_range(0, 3));
            bl     = BW'($urandom_range(0, 7));
            lfsr   = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cv32e40s_dummy_instr_gen.md
Name: cv32e40s_dummy_instr_gen

Overview:
Parametrised successor to the single-shot dummy instruction inserter. It counts issued instructions and, after an LFSR-randomised interval, emits a burst of 1..MAX_BURST dummy instructions (ADD/MUL/AND/BLTU to x0, offset 0). Beats are delivered over a valid/ready handshake to the IF-stage instruction mux. It sits between xsecure control (LFSR, cpuctrl fields) and the IF stage, and requests an LFSR advance per consumed beat.

Parameters:
- MAX_DUMMY_INTERVAL, 64, maximum number of issued instructions between bursts. Power of 2, at least 4.
- MAX_BURST, 4, maximum dummy instructions per burst. At least 1.
- MUL_EN, 1, when 0 the MUL encoding is replaced by ADD (core without M extension).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- instr_issued_i  in  1  a real instruction issued this cycle
- allow_dummy_i  in  1  controller permits insertion
- rnddummy_i  in  1  cpuctrl.rnddummy enable
- rnddummyfreq_i  in  IW-2  frequency mask, where IW = $clog2(MAX_DUMMY_INTERVAL)
- burst_len_i  in  BW  requested beats per burst, where BW = $clog2(MAX_BURST)+1
- cntrst_i  in  1  counter reset request from xsecure_ctrl (CSR updates)
- lfsr_i  in  32  current LFSR value
- dummy_valid_o  out  1  dummy beat available
- dummy_ready_i  in  1  IF accepts the beat
- dummy_instr_o  out  32  encoded dummy instruction
- dummy_last_o  out  1  current beat is the last of the burst
- lfsr_shift_o  out  1  one-cycle pulse that advances the LFSR source
- busy_o  out  1  FSM is not in COUNT

Behaviour:
- Reset (synchronous, rst_n=0 at posedge): FSM=COUNT, cnt_q=0, thr_q=0, beat_q=0, instr_q=0. All outputs are 0.
- en = allow_dummy_i && rnddummy_i.
- Threshold: thr_q = lfsr_i[IW+23:24] & {rnddummyfreq_i, 2'b11}. It is sampled whenever the counter resets, and at reset.
- Effective burst length: L = 1 when burst_len_i = 0; L = MAX_BURST when burst_len_i > MAX_BURST; otherwise L = burst_len_i. L is latched on COUNT->ISSUE.
- Counter: CNT_W = $clog2(MAX_DUMMY_INTERVAL+1). The counter resets when !en, when cntrst_i is set, or on the COUNT->ISSUE transition. Otherwise it increments on instr_issued_i and never wraps. The counter updates only while rnddummy_i=1.
- FSM state COUNT:
  - Go to ISSUE when en && cnt_q > thr_q.
  - The transition cycle latches instr_q from lfsr_i and sets beat_q=0.
- FSM state ISSUE:
  - dummy_valid_o=1.
  - instr_q, dummy_instr_o and dummy_last_o stay stable until dummy_valid_o && dummy_ready_i.
  - On a handshake, lfsr_shift_o pulses for one cycle and beat_q increments.
  - If the beat was last, or en=0, go to COUNT.
  - Otherwise go to GAP.
- FSM state GAP:
  - Lasts one cycle while the shifted LFSR settles.
  - dummy_valid_o=0.
  - Latch a new instr_q from lfsr_i, then return to ISSUE.
  - If en=0 during GAP, go to COUNT and drop the remaining beats.
- Latency: dummy_valid_o rises on the cycle after the threshold is crossed.
- Minimum beat spacing is 2 cycles.
- Abort rule:
  - A beat that is already valid is never withdrawn when en falls; it completes on the handshake.
  - cntrst_i does not abort a burst.
- dummy_last_o = (beat_q == L-1) in ISSUE.
- busy_o = 1 in ISSUE or GAP.
- Encoding, selected by lfsr_i[1:0] at latch time:
  - 00 ADD (f7=0, f3=000, OP)
  - 01 MUL (f7=0000001, f3=000, OP); ADD instead when MUL_EN=0
  - 10 AND (f7=0, f3=111, OP)
  - 11 BLTU (f3=110, BRANCH, imm=0)
  - rs1 = lfsr_i[12:8], rs2 = lfsr_i[20:16].
  - rd = x0 for the OP encodings; the imm bits are 0 for BRANCH.
- Simultaneous events:
  - Threshold crossing and cntrst_i in the same cycle: insertion wins, and the counter and threshold reset.
  - instr_issued_i in the transition cycle is not counted.

Decomposition:
- Shared package cv32e40s_pkg receives:
  - dummy_gen_state_e {COUNT, ISSUE, GAP}
  - the FUNCT3_/FUNCT7_ dummy constants
  - a function dummy_encode(lfsr[31:0], mul_en) returning the 32-bit instruction
- One natural sub-module: cv32e40s_dummy_interval_cnt, containing the counter, threshold sampling and compare. It outputs interval_hit.

Test Plan:
- Reset, then rnddummy_i=1, allow=1, freq=0, lfsr_i[29:24]=6'h3F (thr=3), burst_len=1, ready=1: four issues, then valid on the next cycle with dummy_last_o=1, one lfsr_shift_o pulse, and busy_o drops after the beat.
- lfsr_i=0x00_0A_05_02 (AND, rs1=5, rs2=10): dummy_instr_o=0x00A2F033. With lfsr_i[1:0]=11 and the same rs1/rs2: dummy_instr_o=0x00A2E063 (BLTU).
- burst_len=3, ready held low for 5 cycles on beat 0: instr is stable and there is no shift pulse. After release, three handshakes occur with a GAP between them, dummy_last_o is set on the third, and exactly 3 lfsr_shift_o pulses are seen.
- allow_dummy_i dropped while beat 1 of 4 is valid: beat 1 completes on ready, there is no beat 2, the FSM returns to COUNT, and cnt_q=0.
- burst_len=0 gives 1 beat; burst_len=7 with MAX_BURST=4 gives 4 beats. MUL_EN=0 with lfsr_i[1:0]=01 gives funct7=0.
- rst_n=0 mid-burst with valid=1: on the next posedge all outputs are 0 and the FSM is in COUNT. Asserting cntrst_i each cycle with threshold not yet reached: no insertion is ever made.
